// File: rtl/sva_result_collector.sv
// Collects SVA checker result pulses: timestamps them with the user-clock period,
// queues them in a show-ahead event FIFO and keeps saturating counters and sticky flags.
module sva_result_collector #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                gclk_posedge_flag,
  input  logic                succ,
  input  logic                fail,
  input  logic                lazy_succ,
  input  logic                clr,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_kind,
  output logic [PERIOD_W-1:0] evt_period,
  output logic [CNT_W-1:0]    succ_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic [CNT_W-1:0]    lazy_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                first_fail_valid,
  output logic [PERIOD_W-1:0] first_fail_period,
  output logic                overflow,
  output logic                multi_err,
  output logic [PERIOD_W-1:0] period_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = PERIOD_W + 2;

  localparam logic [1:0] KIND_SUCC = 2'b01;
  localparam logic [1:0] KIND_FAIL = 2'b10;
  localparam logic [1:0] KIND_LAZY = 2'b11;

  logic [PERIOD_W-1:0] r_period;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]    r_succ_cnt;
  logic [CNT_W-1:0]    r_fail_cnt;
  logic [CNT_W-1:0]    r_lazy_cnt;
  logic [CNT_W-1:0]    r_drop_cnt;
  logic                r_ff_valid;
  logic [PERIOD_W-1:0] r_ff_period;
  logic                r_overflow;
  logic                r_multi_err;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_accept;
  logic                w_drop;
  logic                w_multi;
  logic [1:0]          w_nres;
  logic [1:0]          w_kind;
  logic [EW-1:0]       w_head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Priority decode: fail beats succ beats lazy_succ
  always_comb begin
    w_kind = 2'b00;
    if (fail)           w_kind = KIND_FAIL;
    else if (succ)      w_kind = KIND_SUCC;
    else if (lazy_succ) w_kind = KIND_LAZY;
  end

  assign w_nres   = 2'(succ) + 2'(fail) + 2'(lazy_succ);
  assign w_multi  = (w_nres > 2'd1) && !clr;
  assign w_push   = (succ || fail || lazy_succ) && !clr;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop    = !w_empty && evt_ready && !clr;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign evt_valid  = !w_empty;
  assign evt_kind   = w_empty ? 2'b00 : w_head[EW-1 -: 2];
  assign evt_period = w_empty ? '0 : w_head[PERIOD_W-1:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_period <= '0;
    end else if (gclk_posedge_flag) begin
      r_period <= r_period + PERIOD_W'(1);
    end
  end

  // Event FIFO storage and pointers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {w_kind, r_period};
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Counters and sticky status
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_succ_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_lazy_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_period <= '0;
      r_overflow  <= 1'b0;
      r_multi_err <= 1'b0;
    end else if (clr) begin
      r_succ_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_lazy_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_period <= '0;
      r_overflow  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      if (w_push) begin
        case (w_kind)
          KIND_SUCC: r_succ_cnt <= sat_inc(r_succ_cnt);
          KIND_FAIL: r_fail_cnt <= sat_inc(r_fail_cnt);
          KIND_LAZY: r_lazy_cnt <= sat_inc(r_lazy_cnt);
          default:   ;
        endcase
      end
      if (w_push && (w_kind == KIND_FAIL) && !r_ff_valid) begin
        r_ff_valid  <= 1'b1;
        r_ff_period <= r_period;
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
        r_overflow <= 1'b1;
      end
      if (w_multi) begin
        r_multi_err <= 1'b1;
      end
    end
  end

  assign succ_cnt          = r_succ_cnt;
  assign fail_cnt          = r_fail_cnt;
  assign lazy_cnt          = r_lazy_cnt;
  assign drop_cnt          = r_drop_cnt;
  assign first_fail_valid  = r_ff_valid;
  assign first_fail_period = r_ff_period;
  assign overflow          = r_overflow;
  assign multi_err         = r_multi_err;
  assign period_cnt        = r_period;

endmodule

// File: doc/sva_result_collector.md
Name: sva_result_collector

Overview:
- Downstream consumer of the SVA checker FSM's per-evaluation result pulses (succ, fail, lazy_succ).
- Timestamps each result with the user-clock period in which it occurred.
- Buffers results in an event FIFO that is drained over a valid/ready stream.
- Keeps saturating per-kind counters, a sticky first-failure record and error flags, readable by the bench or by a host logger.

Parameters:
- PERIOD_W, 16, width of the gclk period counter and of the event timestamp.
- CNT_W, 16, width of the succ/fail/lazy counters and of drop_cnt.
- DEPTH, 8, event FIFO depth; must be a power of two, at least 2.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- gclk_posedge_flag  in  1  one-cycle pulse marking a user-clock rising edge (from the checker's edge detector).
- succ  in  1  result pulse: thread reached SEND.
- fail  in  1  result pulse: thread failed.
- lazy_succ  in  1  result pulse: thread reached SLAZY.
- clr  in  1  synchronous clear of counters, FIFO and sticky flags.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head.
- evt_kind  out  2  head kind: 01=succ, 10=fail, 11=lazy; 00 never output.
- evt_period  out  PERIOD_W  head timestamp.
- succ_cnt  out  CNT_W  saturating succ count.
- fail_cnt  out  CNT_W  saturating fail count.
- lazy_cnt  out  CNT_W  saturating lazy count.
- drop_cnt  out  CNT_W  saturating count of events lost to FIFO full.
- first_fail_valid  out  1  sticky: a fail has been seen.
- first_fail_period  out  PERIOD_W  timestamp of the first fail.
- overflow  out  1  sticky: at least one event was dropped.
- multi_err  out  1  sticky: more than one result input was high in the same cycle.
- period_cnt  out  PERIOD_W  current period number.

Behaviour:
- Interface: one clock sys_clk; reset sys_rst_n is asynchronous, active-low. All state resets on sys_rst_n low.
- Reset values: every output is 0; the FIFO is empty.
- period_cnt:
  - Registered; increments by 1 on the cycle after gclk_posedge_flag is sampled high.
  - Wraps modulo 2^PERIOD_W.
  - Not affected by clr.
  - An event sampled in cycle t is tagged with the period_cnt value registered in cycle t.
- Event decode, per cycle:
  - At most one kind is pushed per cycle, priority fail > succ > lazy_succ.
  - If two or more inputs are high in the same cycle: multi_err is set, only the priority winner is pushed and counted, and the losers are discarded.
- Counters:
  - The counter for the pushed kind increments in the cycle after the pulse.
  - All counters saturate at 2^CNT_W - 1, with no wrap.
  - Counting happens regardless of FIFO space.
- First fail: on the first fail since reset or clr, first_fail_period captures the tag and first_fail_valid is set. Later fails do not update either.
- FIFO:
  - Show-ahead: evt_valid, evt_kind and evt_period reflect the head combinationally from registered state.
  - Pop occurs when evt_valid and evt_ready are both high.
  - Write latency: a pushed event becomes visible as the head (if the FIFO was empty) in the cycle after the pulse. There is no bypass.
  - Full without a pop in the same cycle: the event is dropped, drop_cnt increments (saturating) and overflow is set.
  - Full with a pop in the same cycle: the push is accepted and occupancy is unchanged.
  - Empty: evt_valid = 0, evt_kind = 0, evt_period = 0. evt_ready is ignored.
  - Pointers are log2(DEPTH) + 1 bits and wrap naturally.
- clr:
  - Next cycle, the following are zero: all counters, drop_cnt, the sticky flags, first_fail_period and the FIFO contents.
  - clr has priority over a same-cycle event (the event is discarded and not counted) and over a same-cycle pop.
- Reset mid-operation: the FIFO is flushed immediately and asynchronously, and evt_valid drops without waiting for a handshake.
- Consumer stalls: evt_valid must stay high and the head must stay stable until accepted.

Test Plan:
- Reset, then 3 gclk_posedge_flag pulses, then succ -> period_cnt=3; next cycle evt_valid=1, evt_kind=01, evt_period=3, succ_cnt=1.
- fail in period 5, then fail in period 7, with evt_ready=1 -> first_fail_valid=1, first_fail_period=5, fail_cnt=2, and two events popped with periods 5 and 7.
- DEPTH=8, evt_ready=0, 10 succ pulses -> 8 events held, drop_cnt=2, overflow=1, succ_cnt=10. Then evt_ready=1 drains 8 events in order with evt_valid low afterwards.
- FIFO full, with succ and evt_ready high in the same cycle -> push accepted, occupancy stays 8, drop_cnt unchanged.
- succ and fail high in the same cycle -> multi_err=1, single event of kind 10, fail_cnt=1, succ_cnt=0.
- CNT_W=4: 20 lazy_succ pulses -> lazy_cnt saturates at 15. Then clr together with a succ pulse -> all counters and flags are 0, the FIFO is empty and period_cnt is preserved.
